// File: rtl/nios_sys_mem_loader_pkg.sv
// Shared definitions for the Nios on-chip RAM loader.
//   LANES/BYTE_W : byte-lane geometry of the 32-bit RAM word
//   ST_*         : loader FSM state encodings (also visible on dbg_state)
//   be_mask()    : expands a 4-bit byteenable into a 32-bit data mask
package nios_sys_mem_loader_pkg;
  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_VRD   = 3'd3;
  localparam logic [2:0] ST_VWAIT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) m[k*BYTE_W +: BYTE_W] = {BYTE_W{be[k]}};
    return m;
  endfunction
endpackage

// File: rtl/nios_sys_mem_loader_if.sv
// Byte-stream input and Avalon-MM RAM port of the loader.
// Stream handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high; the source holds in_data/in_last stable while
// in_valid is high and in_ready is low. in_last marks the final image byte.
//   master : the loader (consumes the stream, drives the RAM port)
//   slave  : the environment (stream source + RAM)
interface nios_sys_mem_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (
    input  in_valid, in_data, in_last, avm_readdata,
    output in_ready, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
  );
  modport slave (
    output in_valid, in_data, in_last, avm_readdata,
    input  in_ready, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
  );
endinterface

// File: rtl/nios_sys_mem_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
//   clear_i      : drop any partial word
//   fire_i       : a byte is accepted this cycle (data_i, last_i)
//   word_valid_o : the accepted byte completes a word (lane 3 or last)
//   word_data_o  : completed word, unfilled lanes 0 (valid with word_valid_o)
//   word_be_o    : filled-lane mask of the completed word
module nios_sys_byte_packer
  import nios_sys_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        fire_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        word_valid_o,
  output logic [31:0] word_data_o,
  output logic [3:0]  word_be_o
);
  logic [1:0]  lane_q;
  logic [31:0] pack_q;
  logic [3:0]  mask_q;
  logic [31:0] pack_d;
  logic [3:0]  mask_d;

  // Merge the incoming byte so a completing word leaves this cycle without
  // waiting for the pack register.
  always_comb begin
    pack_d = pack_q;
    pack_d[{lane_q, 3'b000} +: BYTE_W] = data_i;
    mask_d = mask_q | (4'b0001 << lane_q);
  end

  assign word_valid_o = fire_i & ((lane_q == 2'd3) | last_i);
  assign word_data_o  = pack_d;
  assign word_be_o    = mask_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      pack_q <= '0;
      mask_q <= '0;
    end else if (clear_i || word_valid_o) begin
      lane_q <= '0;
      pack_q <= '0;
      mask_q <= '0;
    end else if (fire_i) begin
      lane_q <= lane_q + 2'd1;
      pack_q <= pack_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: rtl/nios_sys_mem_loader.sv
// Loads a host byte stream into the Nios on-chip RAM starting at base_addr,
// optionally reads the region back and checks an additive checksum.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start, base_addr  : 1-cycle start pulse (ignored while busy), first word address
//   bus               : stream input + Avalon-MM RAM port (master side)
//   busy, cpu_hold    : high from the cycle after start until done
//   done              : 1-cycle completion pulse
//   err_overflow      : sticky, a byte targeted an address beyond DEPTH-1
//   err_verify        : sticky, read-back checksum mismatch
//   word_count        : words written (partial word counts as one)
//   checksum          : sum mod 2^32 of written (lane-masked) words
//   dbg_state         : current FSM state
module nios_sys_mem_loader
  import nios_sys_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  nios_sys_mem_loader_if.master bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_overflow,
  output logic              err_verify,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic [2:0]        dbg_state
);
  localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   next_addr_q;   // one bit wider so overflow is visible, never wraps
  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [3:0]        wr_be_q, last_be_q;
  logic [ADDR_W:0]   word_count_q, rd_idx_q;
  logic [31:0]       checksum_q, vsum_q;
  logic              err_ovf_q, err_ver_q;
  logic              rd_pend_q, rd_last_q;

  logic        byte_fire, addr_oob, ovf_now, rd_is_last, start_ok;
  logic        word_valid;
  logic [31:0] word_data, rd_word, vsum_d;
  logic [3:0]  word_be;

  assign start_ok   = (state_q == ST_IDLE) && start;
  assign byte_fire  = (state_q == ST_LOAD) && bus.in_valid;
  assign addr_oob   = next_addr_q > MAX_ADDR;
  assign ovf_now    = err_ovf_q | (byte_fire & addr_oob);
  assign rd_is_last = rd_idx_q == (word_count_q - (ADDR_W+1)'(1));

  nios_sys_byte_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (start_ok),
    .fire_i       (byte_fire),
    .data_i       (bus.in_data),
    .last_i       (bus.in_last),
    .word_valid_o (word_valid),
    .word_data_o  (word_data),
    .word_be_o    (word_be)
  );

  // Only the final word can be partial, so only it is masked on read-back.
  assign rd_word = bus.avm_readdata & (rd_last_q ? be_mask(last_be_q) : 32'hFFFF_FFFF);
  assign vsum_d  = vsum_q + rd_word;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (byte_fire && bus.in_last) state_d = ovf_now ? ST_DONE : ST_FLUSH;
      ST_FLUSH: state_d = (VERIFY != 0) ? ST_VRD : ST_DONE;
      ST_VRD:   if (rd_is_last) state_d = ST_VWAIT;
      ST_VWAIT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      next_addr_q  <= '0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      last_be_q    <= '0;
      word_count_q <= '0;
      rd_idx_q     <= '0;
      checksum_q   <= '0;
      vsum_q       <= '0;
      err_ovf_q    <= 1'b0;
      err_ver_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Write stage is registered apart from the packer so words stream without stalls.
      wr_q      <= word_valid & ~addr_oob;
      wr_addr_q <= next_addr_q[ADDR_W-1:0];
      wr_data_q <= word_data;
      wr_be_q   <= word_be;
      rd_pend_q <= (state_q == ST_VRD);
      rd_last_q <= (state_q == ST_VRD) && rd_is_last;
      if (start_ok) begin
        base_q       <= base_addr;
        next_addr_q  <= {1'b0, base_addr};
        word_count_q <= '0;
        checksum_q   <= '0;
        err_ovf_q    <= 1'b0;
        err_ver_q    <= 1'b0;
        rd_idx_q     <= '0;
        vsum_q       <= '0;
      end else begin
        if (word_valid && !addr_oob) next_addr_q <= next_addr_q + (ADDR_W+1)'(1);
        if (byte_fire && addr_oob) err_ovf_q <= 1'b1;
        if (wr_q) begin
          word_count_q <= word_count_q + (ADDR_W+1)'(1);
          checksum_q   <= checksum_q + wr_data_q;
          last_be_q    <= wr_be_q;
        end
        if (state_q == ST_VRD) rd_idx_q <= rd_idx_q + (ADDR_W+1)'(1);
        if (rd_pend_q) vsum_q <= vsum_d;
        if (state_q == ST_VWAIT && vsum_d != checksum_q) err_ver_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready       = (state_q == ST_LOAD);
  assign bus.avm_chipselect = wr_q | (state_q == ST_VRD);
  assign bus.avm_write      = wr_q;
  assign bus.avm_address    = wr_q ? wr_addr_q :
                              (state_q == ST_VRD) ? base_q + rd_idx_q[ADDR_W-1:0] : '0;
  assign bus.avm_byteenable = wr_q ? wr_be_q : (state_q == ST_VRD) ? 4'hF : 4'h0;
  assign bus.avm_writedata  = wr_q ? wr_data_q : 32'h0;

  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign cpu_hold     = busy;
  assign done         = (state_q == ST_DONE);
  assign err_overflow = err_ovf_q;
  assign err_verify   = err_ver_q;
  assign word_count   = word_count_q;
  assign checksum     = checksum_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_nios_sys_mem_loader.sv
module tb_nios_sys_mem_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        busy, cpu_hold, done, err_overflow, err_verify;
  logic [10:0] word_count;
  logic [31:0] checksum;
  logic [2:0]  dbg_state;

  nios_sys_mem_loader_if #(.ADDR_W(10)) bus ();

  nios_sys_mem_loader #(.ADDR_W(10), .DEPTH(1024), .VERIFY(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .bus          (bus),
    .busy         (busy),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err_overflow (err_overflow),
    .err_verify   (err_verify),
    .word_count   (word_count),
    .checksum     (checksum),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:1023];
  logic        flip_en = 1'b0;
  logic [9:0]  flip_addr = '0;
  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write) begin
      for (int k = 0; k < 4; k++)
        if (bus.avm_byteenable[k]) mem[bus.avm_address][k*8 +: 8] <= bus.avm_writedata[k*8 +: 8];
    end
    if (bus.avm_chipselect && !bus.avm_write)
      bus.avm_readdata <= mem[bus.avm_address] ^
                          ((flip_en && bus.avm_address == flip_addr) ? 32'h0000_0001 : 32'h0);
  end

  // ---------------- scoreboard: expected writes {addr, be, data} ----------------
  logic [45:0] exp_q[$];
  int rd_cnt = 0;
  bit cad_en = 1'b0;
  int last_wr_cyc = -1;
  always @(negedge clk) begin
    if (bus.avm_chipselect && bus.avm_write) begin
      logic [45:0] got, e;
      got = {bus.avm_address, bus.avm_byteenable, bus.avm_writedata};
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_abd", 64'(got), 64'(e));
      end
      if (cad_en && last_wr_cyc >= 0) check("write_cadence", 64'(cyc - last_wr_cyc), 64'd4);
      last_wr_cyc = cyc;
    end else if (bus.avm_chipselect) begin
      rd_cnt++;
    end
  end

  task automatic exp_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_q.push_back({a, be, d});
  endtask

  // ---------------- drivers ----------------
  int stalls;

  task automatic do_start(input logic [9:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_stream(input int n, input logic [7:0] b0, input logic [7:0] step,
                             input int mid_idx, input bit with_last);
    int i;
    int tries;
    logic [7:0] b;
    i = 0;
    tries = 0;
    b = b0;
    stalls = 0;
    while (i < n && tries < n + 50) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = with_last && (i == n - 1);
      start        = (i == mid_idx);
      if (i == mid_idx) base_addr = 10'h200;
      tries++;
      if (bus.in_ready) begin
        i++;
        b = b + step;
      end else begin
        stalls++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    start        = 1'b0;
    check("stream_sent", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
    if (seen) check("busy_low_at_done", 64'({busy, cpu_hold}), 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] sum;
    logic [7:0]  by [0:3];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    #23;
    check("reset_outputs", 64'({busy, cpu_hold, done, err_overflow, err_verify, bus.in_ready,
                                bus.avm_chipselect, bus.avm_write, bus.avm_byteenable}), 64'd0);
    check("reset_counts", 64'({word_count, checksum}), 64'd0);
    reset_n = 1'b1;

    // idle: stream not consumed
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1 check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;

    // 1: two full words
    exp_write(10'h010, 4'hF, 32'h0403_0201);
    exp_write(10'h011, 4'hF, 32'h0807_0605);
    do_start(10'h010);
    send_stream(8, 8'h01, 8'h01, -1, 1'b1);
    wait_done("t1_done");
    check("t1_word_count", 64'(word_count), 64'd2);
    check("t1_checksum", 64'(checksum), 64'h0C0A_0806);
    check("t1_errs", 64'({err_overflow, err_verify}), 64'd0);

    // 2: partial final word, verify passes
    exp_write(10'h020, 4'hF, 32'hDDCC_BBAA);
    exp_write(10'h021, 4'h3, 32'h0000_FFEE);
    rd_cnt = 0;
    do_start(10'h020);
    send_stream(6, 8'hAA, 8'h11, -1, 1'b1);
    wait_done("t2_done");
    check("t2_word_count", 64'(word_count), 64'd2);
    check("t2_checksum", 64'(checksum), 64'hDDCD_BB98);
    check("t2_reads", 64'(rd_cnt), 64'd2);
    check("t2_errs", 64'({err_overflow, err_verify}), 64'd0);

    // 3: overflow at top of RAM
    exp_write(10'h3FF, 4'hF, 32'h1413_1211);
    rd_cnt = 0;
    do_start(10'h3FF);
    send_stream(8, 8'h11, 8'h01, -1, 1'b1);
    wait_done("t3_done");
    check("t3_err_overflow", 64'(err_overflow), 64'd1);
    check("t3_err_verify", 64'(err_verify), 64'd0);
    check("t3_word_count", 64'(word_count), 64'd1);
    check("t3_checksum", 64'(checksum), 64'h1413_1211);
    check("t3_no_reads", 64'(rd_cnt), 64'd0);

    // 4: corrupted read-back of word 1
    flip_en = 1'b1;
    flip_addr = 10'h041;
    exp_write(10'h040, 4'hF, 32'h2423_2221);
    exp_write(10'h041, 4'hF, 32'h2827_2625);
    do_start(10'h040);
    send_stream(8, 8'h21, 8'h01, -1, 1'b1);
    wait_done("t4_done");
    check("t4_err_verify", 64'(err_verify), 64'd1);
    check("t4_err_overflow", 64'(err_overflow), 64'd0);
    flip_en = 1'b0;

    // 5: reset after 3 bytes, then clean reload
    do_start(10'h050);
    send_stream(3, 8'h31, 8'h01, -1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_outputs", 64'({busy, done, err_overflow, err_verify, bus.in_ready,
                                   bus.avm_chipselect, bus.avm_write, bus.avm_byteenable}), 64'd0);
    check("t5_async_counts", 64'({word_count, checksum}), 64'd0);
    check("t5_async_wdata", 64'(bus.avm_writedata), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_write(10'h050, 4'hF, 32'h3433_3231);
    do_start(10'h050);
    send_stream(4, 8'h31, 8'h01, -1, 1'b1);
    wait_done("t5_done");
    check("t5_word_count", 64'(word_count), 64'd1);
    check("t5_checksum", 64'(checksum), 64'h3433_3231);
    check("t5_errs", 64'({err_overflow, err_verify}), 64'd0);

    // 6: 64-byte burst, start pulse mid-load
    sum = '0;
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) by[k] = 8'(4*w + k);
      exp_write(10'(10'h100 + w), 4'hF, {by[3], by[2], by[1], by[0]});
      sum = sum + {by[3], by[2], by[1], by[0]};
    end
    last_wr_cyc = -1;
    cad_en = 1'b1;
    do_start(10'h100);
    send_stream(64, 8'h00, 8'h01, 20, 1'b1);
    check("t6_no_stalls", 64'(stalls), 64'd0);
    wait_done("t6_done");
    cad_en = 1'b0;
    check("t6_word_count", 64'(word_count), 64'd16);
    check("t6_checksum", 64'(checksum), 64'(sum));
    check("t6_errs", 64'({err_overflow, err_verify}), 64'd0);

    repeat (3) @(negedge clk);
    check("writes_pending", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
